// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event controller: FSM states,
// event type codes, register addresses and the FIFO entry layout.
package button_event_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEB_PRESS,
      ST_HELD,
      ST_REPEAT,
      ST_DEB_REL
   } btn_state_t;

   localparam logic [1:0] EV_SHORT  = 2'b01;
   localparam logic [1:0] EV_LONG   = 2'b10;
   localparam logic [1:0] EV_REPEAT = 2'b11;

   localparam logic [1:0] ADDR_STATUS   = 2'd0;
   localparam logic [1:0] ADDR_EVENT    = 2'd1;
   localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
   localparam logic [1:0] ADDR_CONTROL  = 2'd3;

   typedef struct packed {
      logic [1:0] typ;
      logic [1:0] idx;
   } evt_t;

   // Width of a counter that must hold values 0..n-1.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Avalon-MM slave bus plus interrupt line of the button event controller.
interface button_event_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (output address, chipselect, read, write_n, writedata,
                   input  readdata, irq);
   modport slave  (input  address, chipselect, read, write_n, writedata,
                   output readdata, irq);
endinterface

// File: rtl/button_event_ctrl_btn_fsm.sv
// One button: 2-flop synchronizer, debounce, press/hold/repeat FSM and a
// single-entry pending event slot drained by the top-level FIFO writer.
module btn_fsm
   import button_event_pkg::*;
#(
   parameter int DEB_CYC  = 50000,
   parameter int LONG_CYC = 50000000,
   parameter int REP_CYC  = 12500000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_raw,
   input  logic       ack,
   output logic       level,
   output logic       pend,
   output logic [1:0] pend_type,
   output logic       ovf_set
);

   localparam int DW = cnt_w(DEB_CYC);
   localparam int HW = cnt_w(LONG_CYC);
   localparam int RW = cnt_w(REP_CYC);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYC - 1);

   logic [1:0]    sync_q;
   logic          synced;
   btn_state_t    state, state_nxt;
   logic          from_rep, from_rep_nxt;
   logic [DW-1:0] deb_cnt, deb_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [RW-1:0] rep_cnt, rep_nxt;
   logic          level_nxt;
   logic          post;
   logic [1:0]    post_type;

   assign synced  = sync_q[1];
   // A new post onto an undrained slot overwrites it; that loss is reported.
   assign ovf_set = post & pend & ~ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= '0;
         state     <= ST_IDLE;
         from_rep  <= 1'b0;
         deb_cnt   <= '0;
         hold_cnt  <= '0;
         rep_cnt   <= '0;
         level     <= 1'b0;
         pend      <= 1'b0;
         pend_type <= '0;
      end else begin
         sync_q   <= {sync_q[0], btn_raw};
         state    <= state_nxt;
         from_rep <= from_rep_nxt;
         deb_cnt  <= deb_nxt;
         hold_cnt <= hold_nxt;
         rep_cnt  <= rep_nxt;
         level    <= level_nxt;
         if (post) begin
            pend      <= 1'b1;
            pend_type <= post_type;
         end else if (ack) begin
            pend <= 1'b0;
         end
      end
   end

   // Counters only advance below their terminal value, so they saturate.
   always_comb begin
      state_nxt    = state;
      from_rep_nxt = from_rep;
      deb_nxt      = deb_cnt;
      hold_nxt     = hold_cnt;
      rep_nxt      = rep_cnt;
      level_nxt    = level;
      post         = 1'b0;
      post_type    = EV_SHORT;
      case (state)
         ST_IDLE: begin
            if (synced) begin
               state_nxt = ST_DEB_PRESS;
               deb_nxt   = '0;
            end
         end
         ST_DEB_PRESS: begin
            if (!synced) begin
               state_nxt = ST_IDLE;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = ST_HELD;
               level_nxt = 1'b1;
               hold_nxt  = '0;
            end else begin
               deb_nxt = deb_cnt + 1'b1;
            end
         end
         ST_HELD: begin
            if (!synced) begin
               state_nxt    = ST_DEB_REL;
               from_rep_nxt = 1'b0;
               deb_nxt      = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt = ST_REPEAT;
               rep_nxt   = '0;
               post      = 1'b1;
               post_type = EV_LONG;
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         ST_REPEAT: begin
            if (!synced) begin
               state_nxt    = ST_DEB_REL;
               from_rep_nxt = 1'b1;
               deb_nxt      = '0;
            end else if (rep_cnt == REP_LAST) begin
               rep_nxt   = '0;
               post      = 1'b1;
               post_type = EV_REPEAT;
            end else begin
               rep_nxt = rep_cnt + 1'b1;
            end
         end
         ST_DEB_REL: begin
            // Bounce back keeps hold/repeat progress intact.
            if (synced) begin
               state_nxt = from_rep ? ST_REPEAT : ST_HELD;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = ST_IDLE;
               level_nxt = 1'b0;
               post      = ~from_rep;
               post_type = EV_SHORT;
            end else begin
               deb_nxt = deb_cnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: N_BTN debounced button FSMs feeding an event FIFO
// read over an Avalon-MM slave, with a level interrupt.
module button_event_ctrl
   import button_event_pkg::*;
#(
   parameter int N_BTN      = 4,
   parameter int DEB_CYC    = 50000,
   parameter int LONG_CYC   = 50000000,
   parameter int REP_CYC    = 12500000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_BTN-1:0]   btn_in,
   button_event_ctrl_if.slave bus
);

   localparam int AW = cnt_w(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [N_BTN-1:0]      level, pend, ack, ovf_set;
   logic [N_BTN-1:0][1:0] pend_type;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_fsm #(
         .DEB_CYC  (DEB_CYC),
         .LONG_CYC (LONG_CYC),
         .REP_CYC  (REP_CYC)
      ) u_btn (
         .clk       (clk),
         .reset_n   (reset_n),
         .btn_raw   (btn_in[i]),
         .ack       (ack[i]),
         .level     (level[i]),
         .pend      (pend[i]),
         .pend_type (pend_type[i]),
         .ovf_set   (ovf_set[i])
      );
   end

   // Fixed priority: lowest pending index is taken each clock.
   logic push_req;
   evt_t push_evt;
   always_comb begin
      ack      = '0;
      push_req = 1'b0;
      push_evt = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (pend[i] && !push_req) begin
            push_req     = 1'b1;
            ack[i]       = 1'b1;
            push_evt.typ = pend_type[i];
            push_evt.idx = 2'(i);
         end
      end
   end

   evt_t          mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          empty, full, ovf;
   logic [1:0]    mask;
   logic [31:0]   rdata_q, status;
   logic          rd, wr, pop, flush, ovf_clr, do_push, drop;
   logic          unused;

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign rd      = bus.chipselect & bus.read;
   assign wr      = bus.chipselect & ~bus.write_n;
   assign pop     = rd & (bus.address == ADDR_EVENT) & ~empty;
   assign flush   = wr & (bus.address == ADDR_CONTROL) & bus.writedata[1];
   assign ovf_clr = wr & (bus.address == ADDR_CONTROL) & bus.writedata[0];
   // A concurrent pop frees the slot a full FIFO would otherwise refuse.
   assign do_push = push_req & ~flush & (~full | pop);
   assign drop    = push_req & ~flush & full & ~pop;
   assign unused  = ^bus.writedata[31:2];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_evt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !pop)      count <= count + 1'b1;
         else if (pop && !do_push) count <= count - 1'b1;
      end
   end

   always_comb begin
      status              = '0;
      status[N_BTN-1:0]   = level;
      status[8]           = empty;
      status[9]           = full;
      status[10]          = ovf;
      status[15:12]       = 4'(count);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf     <= 1'b0;
         mask    <= '0;
         rdata_q <= '0;
      end else begin
         if (ovf_clr) ovf <= 1'b0;
         if ((|ovf_set) || drop) ovf <= 1'b1;
         if (wr && bus.address == ADDR_IRQ_MASK) mask <= bus.writedata[1:0];
         if (rd) begin
            case (bus.address)
               ADDR_STATUS:   rdata_q <= status;
               ADDR_EVENT:    rdata_q <= empty ? 32'd0 : {1'b1, 27'd0, mem[rd_ptr]};
               ADDR_IRQ_MASK: rdata_q <= {30'd0, mask};
               default:       rdata_q <= '0;
            endcase
         end
      end
   end

   assign bus.readdata = rdata_q;
   assign bus.irq      = (mask[0] & ~empty) | (mask[1] & ovf);

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl with short debounce/hold timings.
module tb_button_event_ctrl;
   import button_event_pkg::*;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b1;
   logic [3:0] btn_in  = '0;

   button_event_ctrl_if bus();

   button_event_ctrl #(
      .N_BTN(4), .DEB_CYC(4), .LONG_CYC(20), .REP_CYC(8), .FIFO_DEPTH(4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_in  (btn_in),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] rd_val;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Bus tasks are entered at a negedge and consume exactly one clock.
   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = a;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      d = bus.readdata;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = a;
      bus.writedata  = d;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic press(input int idx, input int n_hi, input int n_lo);
      btn_in[idx] = 1'b1;
      repeat (n_hi) @(negedge clk);
      btn_in[idx] = 1'b0;
      repeat (n_lo) @(negedge clk);
   endtask

   task automatic pop_chk(input string tag);
      logic [31:0] e;
      logic [31:0] d;
      e = 32'h0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      bus_rd(ADDR_EVENT, d);
      chk(tag, d, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;

      #1 reset_n = 1'b0;
      #1;
      chk("rst_readdata", bus.readdata, 32'h0);
      chk("rst_irq", {31'd0, bus.irq}, 32'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      bus_rd(ADDR_STATUS, rd_val);   chk("rst_status", rd_val, 32'h0000_0100);
      bus_rd(ADDR_IRQ_MASK, rd_val); chk("rst_mask", rd_val, 32'h0);

      // 2-clock glitch must never reach the debounced level
      btn_in[0] = 1'b1;
      repeat (2) @(negedge clk);
      btn_in[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus_rd(ADDR_STATUS, rd_val);
         chk("glitch_status", rd_val, 32'h0000_0100);
      end
      pop_chk("glitch_no_event");

      // short press on button 1 with not-empty interrupt
      bus_wr(ADDR_IRQ_MASK, 32'h1);
      exp_q.push_back(32'h8000_0005);
      press(1, 10, 12);
      chk("short_irq_set", {31'd0, bus.irq}, 32'h1);
      bus_rd(ADDR_STATUS, rd_val); chk("short_status", rd_val, 32'h0000_1000);
      pop_chk("short_event");
      chk("short_irq_clr", {31'd0, bus.irq}, 32'h0);

      // long hold on button 2: LONG then two REPEATs, no SHORT on release
      btn_in[2] = 1'b1;
      repeat (20) @(negedge clk);
      bus_rd(ADDR_STATUS, rd_val); chk("hold_level", rd_val, 32'h0000_0104);
      repeat (21) @(negedge clk);
      btn_in[2] = 1'b0;
      exp_q.push_back(32'h8000_000A);
      exp_q.push_back(32'h8000_000E);
      exp_q.push_back(32'h8000_000E);
      repeat (12) @(negedge clk);
      pop_chk("long_event");
      pop_chk("repeat_event1");
      pop_chk("repeat_event2");
      pop_chk("no_short_after_long");

      // simultaneous release: lower index first
      btn_in[0] = 1'b1; btn_in[3] = 1'b1;
      repeat (10) @(negedge clk);
      btn_in[0] = 1'b0; btn_in[3] = 1'b0;
      exp_q.push_back(32'h8000_0004);
      exp_q.push_back(32'h8000_0007);
      repeat (12) @(negedge clk);
      pop_chk("order_first");
      pop_chk("order_second");
      pop_chk("order_empty");

      // overflow: six SHORTs into a 4-deep FIFO
      for (int i = 0; i < 6; i++) begin
         if (i < 4) exp_q.push_back(32'h8000_0005);
         press(1, 10, 12);
      end
      bus_rd(ADDR_STATUS, rd_val); chk("ovf_status", rd_val, 32'h0000_4600);
      bus_wr(ADDR_IRQ_MASK, 32'h2);
      chk("ovf_irq", {31'd0, bus.irq}, 32'h1);
      bus_wr(ADDR_CONTROL, 32'h1);
      chk("ovf_irq_clr", {31'd0, bus.irq}, 32'h0);
      bus_rd(ADDR_STATUS, rd_val); chk("ovf_cleared", rd_val, 32'h0000_4200);
      for (int i = 0; i < 4; i++) pop_chk("ovf_drain");
      pop_chk("ovf_drain_empty");

      // async reset while button 3 is in REPEAT
      bus_wr(ADDR_IRQ_MASK, 32'h3);
      btn_in[3] = 1'b1;
      repeat (30) @(negedge clk);
      bus_rd(ADDR_STATUS, rd_val); chk("pre_rst_status", rd_val, 32'h0000_1008);
      chk("pre_rst_irq", {31'd0, bus.irq}, 32'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_readdata", bus.readdata, 32'h0);
      chk("mid_rst_irq", {31'd0, bus.irq}, 32'h0);
      btn_in[3] = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      bus_rd(ADDR_STATUS, rd_val);   chk("post_rst_status", rd_val, 32'h0000_0100);
      bus_rd(ADDR_IRQ_MASK, rd_val); chk("post_rst_mask", rd_val, 32'h0);
      pop_chk("post_rst_no_event");
      exp_q.push_back(32'h8000_0007);
      press(3, 10, 12);
      pop_chk("post_rst_new_press");

      if (exp_q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
